// File: rtl/msrv32_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response plus the decode-side instruction handshake.
// A transfer happens on a rising clk edge where the producer's valid/req is high together with the consumer's ready.
interface msrv32_fetch_unit_if;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ready_in;
    logic        imem_rvalid_in;
    logic [31:0] imem_rdata_in;
    logic        instr_valid_out;
    logic        instr_ready_in;
    logic [31:0] instr_out;
    logic [31:0] pc_out;

    modport master (
        output imem_req_out, imem_addr_out, instr_valid_out, instr_out, pc_out,
        input  imem_ready_in, imem_rvalid_in, imem_rdata_in, instr_ready_in
    );

    modport slave (
        input  imem_req_out, imem_addr_out, instr_valid_out, instr_out, pc_out,
        output imem_ready_in, imem_rvalid_in, imem_rdata_in, instr_ready_in
    );
endinterface

// File: rtl/msrv32_fetch_unit.sv
// msrv32 instruction fetch: PC owner, one outstanding imem request, valid/ready hand-off to decode.
// Optional macro MSRV32_FETCH_BYPASS_EN forwards the memory response to decode in the same cycle.
module msrv32_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        branch_taken_in,
    input  logic        redirect_valid_in,
    input  logic [31:0] target_in,
    input  logic        trap_taken_in,
    input  logic [31:0] trap_pc_in,
    output logic        misaligned_instr_out,
    output logic [1:0]  state_dbg_out,
    msrv32_fetch_unit_if.master bus_if
);
    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_REQ  = 2'd1;
    localparam logic [1:0]  S_RSP  = 2'd2;
    localparam logic [1:0]  S_HOLD = 2'd3;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic [1:0]  r_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic        r_kill;

    logic        w_branch_ok;
    logic        w_redirect;
    logic [31:0] w_new_pc;
    logic [1:0]  w_next_state;
    logic [31:0] w_next_fetch_pc;
    logic        w_next_kill;
    logic        w_capture;

    // Trap wins over a branch; a misaligned branch target never redirects.
    assign w_branch_ok = redirect_valid_in & branch_taken_in & (target_in[1:0] == 2'b00);
    assign w_redirect  = trap_taken_in | w_branch_ok;
    assign w_new_pc    = trap_taken_in ? trap_pc_in : target_in;

    assign misaligned_instr_out = ~rst_in & ~trap_taken_in & redirect_valid_in &
                                  branch_taken_in & (target_in[1:0] != 2'b00);

    assign state_dbg_out        = r_state;
    assign bus_if.imem_req_out  = (r_state == S_REQ);
    assign bus_if.imem_addr_out = r_fetch_pc;

`ifdef MSRV32_FETCH_BYPASS_EN
    logic w_bypass;
    assign w_bypass               = (r_state == S_RSP) & bus_if.imem_rvalid_in & ~r_kill;
    assign bus_if.instr_valid_out = (r_state == S_HOLD) | w_bypass;
    assign bus_if.instr_out       = w_bypass ? bus_if.imem_rdata_in : r_instr;
    assign bus_if.pc_out          = w_bypass ? r_fetch_pc : r_pc;
`else
    assign bus_if.instr_valid_out = (r_state == S_HOLD);
    assign bus_if.instr_out       = r_instr;
    assign bus_if.pc_out          = r_pc;
`endif

    always_comb begin
        w_next_state    = r_state;
        w_next_fetch_pc = w_redirect ? w_new_pc : r_fetch_pc;
        w_next_kill     = r_kill;
        w_capture       = 1'b0;
        case (r_state)
            S_IDLE: w_next_state = S_REQ;
            S_REQ: begin
                // An accepted request whose PC is being replaced must have its response dropped.
                if (bus_if.imem_ready_in) begin
                    w_next_state = S_RSP;
                    w_next_kill  = w_redirect;
                end
            end
            S_RSP: begin
                if (bus_if.imem_rvalid_in) begin
                    if (r_kill | w_redirect) begin
                        w_next_state = S_REQ;
                        w_next_kill  = 1'b0;
                    end else begin
`ifdef MSRV32_FETCH_BYPASS_EN
                        if (bus_if.instr_ready_in) begin
                            w_next_state    = S_REQ;
                            w_next_fetch_pc = r_fetch_pc + 32'd4;
                        end else begin
                            w_next_state = S_HOLD;
                            w_capture    = 1'b1;
                        end
`else
                        w_next_state = S_HOLD;
                        w_capture    = 1'b1;
`endif
                    end
                end else begin
                    w_next_kill = r_kill | w_redirect;
                end
            end
            S_HOLD: begin
                if (w_redirect) begin
                    w_next_state = S_REQ;
                end else if (bus_if.instr_ready_in) begin
                    w_next_state    = S_REQ;
                    w_next_fetch_pc = r_pc + 32'd4;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_kill     <= 1'b0;
            r_instr    <= NOP;
            r_pc       <= RESET_PC;
        end else begin
            r_state    <= w_next_state;
            r_fetch_pc <= w_next_fetch_pc;
            r_kill     <= w_next_kill;
            if (w_capture) begin
                r_instr <= bus_if.imem_rdata_in;
                r_pc    <= r_fetch_pc;
            end
        end
    end
endmodule

// File: tb/tb_msrv32_fetch_unit.sv
// Bench for msrv32_fetch_unit: directed vectors, kill/reset sequences and random traffic against a program-order model.
`timescale 1ns/1ps
module tb_msrv32_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic        trap;
        logic [31:0] trap_pc;
        logic        rv;
        logic        bt;
        logic [31:0] target;
        logic [31:0] exp_addr;
        logic        exp_mis;
    } vec_t;

    logic        clk_in;
    logic        rst_in;
    logic        branch_taken_in;
    logic        redirect_valid_in;
    logic [31:0] target_in;
    logic        trap_taken_in;
    logic [31:0] trap_pc_in;
    logic        misaligned_instr_out;
    logic [1:0]  state_dbg_out;

    msrv32_fetch_unit_if bus_if();

    msrv32_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .branch_taken_in     (branch_taken_in),
        .redirect_valid_in   (redirect_valid_in),
        .target_in           (target_in),
        .trap_taken_in       (trap_taken_in),
        .trap_pc_in          (trap_pc_in),
        .misaligned_instr_out(misaligned_instr_out),
        .state_dbg_out       (state_dbg_out),
        .bus_if              (bus_if)
    );

    // Clock / reset
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Stimulus for the next cycle
    logic        s_rst, s_trap, s_rv, s_bt, s_iready;
    logic [31:0] s_trap_pc, s_target;

    // Memory responder state
    logic        m_rand_ready, m_pend, m_override_en, m_dead_sent;
    int unsigned m_dly, m_lat_min, m_lat_max;
    logic [31:0] m_addr, m_override_data;

    // Scoreboard
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;
    logic        acc_seen, hold_pending, saw_dead;
    logic [31:0] acc_addr, held_addr, last_xfer_pc, last_xfer_instr;
    int          total, bad, cyc, xfer_count;
    int          xfer_cyc[$];
    logic [1:0]  idle_code;
    vec_t        vecs[9];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Driver tasks
    task automatic mem_update();
        bus_if.imem_rvalid_in = 1'b0;
        if (rst_in) begin
            m_pend = 1'b0;
        end else begin
            if (acc_seen) begin
                m_pend = 1'b1;
                m_addr = acc_addr;
                m_dly  = $urandom_range(m_lat_min, m_lat_max);
            end
            if (m_pend) begin
                if (m_dly == 0) begin
                    bus_if.imem_rvalid_in = 1'b1;
                    bus_if.imem_rdata_in  = m_override_en ? m_override_data : mem_word(m_addr);
                    if (m_override_en) m_dead_sent = 1'b1;
                    m_override_en = 1'b0;
                    m_pend        = 1'b0;
                end else begin
                    m_dly--;
                end
            end
        end
        bus_if.imem_ready_in = m_rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    endtask

    task automatic apply_stim();
        rst_in                = s_rst;
        trap_taken_in         = s_trap;
        trap_pc_in            = s_trap_pc;
        redirect_valid_in     = s_rv;
        branch_taken_in       = s_bt;
        target_in             = s_target;
        bus_if.instr_ready_in = s_iready;
    endtask

    task automatic clear_redirect();
        s_trap = 1'b0; s_trap_pc = 32'h0; s_rv = 1'b0; s_bt = 1'b0; s_target = 32'h0;
    endtask

    // Sampled at the falling edge: checks this cycle and advances the program-order model.
    task automatic sample();
        logic xfer, redirect, exp_mis;
        cyc++;
        acc_seen = bus_if.imem_req_out && bus_if.imem_ready_in;
        acc_addr = bus_if.imem_addr_out;
        xfer     = bus_if.instr_valid_out && bus_if.instr_ready_in;
        exp_mis  = !rst_in && !trap_taken_in && redirect_valid_in && branch_taken_in &&
                   (target_in[1:0] != 2'b00);
        chk("misaligned", {31'b0, misaligned_instr_out}, {31'b0, exp_mis});
        if (hold_pending) begin
            chk("held_req", {31'b0, bus_if.imem_req_out}, 32'd1);
            chk("held_addr", bus_if.imem_addr_out, held_addr);
        end
        redirect     = trap_taken_in || (redirect_valid_in && branch_taken_in && target_in[1:0] == 2'b00);
        hold_pending = bus_if.imem_req_out && !bus_if.imem_ready_in && !redirect && !rst_in;
        held_addr    = bus_if.imem_addr_out;
        if (xfer && !rst_in) begin
            xfer_count++;
            xfer_cyc.push_back(cyc);
            last_xfer_pc    = bus_if.pc_out;
            last_xfer_instr = bus_if.instr_out;
            if (bus_if.instr_out == 32'hDEAD_BEEF) saw_dead = 1'b1;
            chk("xfer_pc", bus_if.pc_out, exp_pc);
            chk("xfer_instr", bus_if.instr_out, mem_word(exp_pc));
        end
        if (rst_in)                                                      exp_pc = RESET_PC;
        else if (trap_taken_in)                                          exp_pc = trap_pc_in;
        else if (redirect_valid_in && branch_taken_in && target_in[1:0] == 2'b00) exp_pc = target_in;
        else if (xfer)                                                   exp_pc = exp_pc + 32'd4;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        mem_update();
        apply_stim();
        @(negedge clk_in);
        sample();
    endtask

    task automatic wait_hold(input logic [31:0] exp_hold_pc);
        int k = 0;
        do begin
            tick();
            k++;
        end while (!bus_if.instr_valid_out && k < 20);
        chk("hold_valid", {31'b0, bus_if.instr_valid_out}, 32'd1);
        chk("hold_pc", bus_if.pc_out, exp_hold_pc);
        chk("hold_instr", bus_if.instr_out, mem_word(exp_hold_pc));
        chk("hold_dbg_not_idle", {31'b0, state_dbg_out != idle_code}, 32'd1);
    endtask

    initial begin
        int rel_cyc, n0, r;
        logic first_acc;

        vecs[0] = '{32'h0000_0010, 1'b0, 32'h0,  1'b1, 1'b1, 32'h0000_0100, 32'h0000_0100, 1'b0};
        vecs[1] = '{32'h0000_0100, 1'b0, 32'h0,  1'b1, 1'b1, 32'h0000_0102, 32'h0000_0104, 1'b1};
        vecs[2] = '{32'h0000_0104, 1'b1, 32'h80, 1'b1, 1'b1, 32'h0000_0300, 32'h0000_0080, 1'b0};
        vecs[3] = '{32'h0000_0080, 1'b1, 32'h40, 1'b1, 1'b1, 32'h0000_0333, 32'h0000_0040, 1'b0};
        vecs[4] = '{32'h0000_0040, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0000_0500, 32'h0000_0044, 1'b0};
        vecs[5] = '{32'h0000_0044, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0000_0600, 32'h0000_0048, 1'b0};
        vecs[6] = '{32'h0000_0048, 1'b0, 32'h0,  1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0};
        vecs[7] = '{32'hFFFF_FFFC, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[8] = '{32'h0000_0000, 1'b0, 32'h0,  1'b1, 1'b1, 32'h0000_0201, 32'h0000_0004, 1'b1};

        total = 0; bad = 0; cyc = 0; xfer_count = 0;
        exp_pc = RESET_PC; acc_seen = 1'b0; acc_addr = 32'h0; hold_pending = 1'b0; held_addr = 32'h0;
        saw_dead = 1'b0; last_xfer_pc = 32'h0; last_xfer_instr = 32'h0;
        m_rand_ready = 1'b0; m_pend = 1'b0; m_dly = 0; m_lat_min = 0; m_lat_max = 0; m_addr = 32'h0;
        m_override_en = 1'b0; m_override_data = 32'h0; m_dead_sent = 1'b0;
        bus_if.imem_ready_in = 1'b1; bus_if.imem_rvalid_in = 1'b0; bus_if.imem_rdata_in = 32'h0;

        // Reset with a simultaneous taken branch: reset must win.
        s_rst = 1'b1; s_iready = 1'b0; clear_redirect();
        s_rv = 1'b1; s_bt = 1'b1; s_target = 32'h0000_0100;
        apply_stim();
        repeat (2) tick();
        chk("rst_req", {31'b0, bus_if.imem_req_out}, 32'd0);
        chk("rst_addr", bus_if.imem_addr_out, RESET_PC);
        chk("rst_valid", {31'b0, bus_if.instr_valid_out}, 32'd0);
        chk("rst_instr", bus_if.instr_out, 32'h0000_0013);
        chk("rst_pc", bus_if.pc_out, RESET_PC);
        idle_code = state_dbg_out;

        // Zero-wait sequential fetch after release.
        s_rst = 1'b0; clear_redirect(); s_iready = 1'b1;
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8); exp_q.push_back(32'hC);
        rel_cyc = cyc;
        for (int k = 1; k <= 40 && xfer_count < 4; k++) begin
            tick();
            if (k == 1) chk("rel_cycle1_req", {31'b0, bus_if.imem_req_out}, 32'd0);
            if (k == 2) chk("rel_cycle2_req", {31'b0, bus_if.imem_req_out}, 32'd1);
            if (acc_seen && exp_q.size() > 0) chk("seq_addr", acc_addr, exp_q.pop_front());
        end
        chk("seq_xfers", xfer_count, 32'd4);
        chk("seq_addr_left", exp_q.size(), 32'd0);
        chk("first_valid_latency", xfer_cyc[0] - rel_cyc, 32'd4);
        chk("rate_1", xfer_cyc[1] - xfer_cyc[0], 32'd3);
        chk("rate_2", xfer_cyc[2] - xfer_cyc[1], 32'd3);

        // Redirect vectors, each applied while an instruction is held.
        for (int i = 0; i < 9; i++) begin
            s_iready = 1'b0; clear_redirect();
            wait_hold(vecs[i].pc);
            s_iready = 1'b1;
            s_trap = vecs[i].trap; s_trap_pc = vecs[i].trap_pc;
            s_rv = vecs[i].rv; s_bt = vecs[i].bt; s_target = vecs[i].target;
            tick();
            chk("vec_mis", {31'b0, misaligned_instr_out}, {31'b0, vecs[i].exp_mis});
            s_iready = 1'b0; clear_redirect();
            tick();
            chk("vec_valid_drop", {31'b0, bus_if.instr_valid_out}, 32'd0);
            chk("vec_req", {31'b0, bus_if.imem_req_out}, 32'd1);
            chk("vec_next_addr", bus_if.imem_addr_out, vecs[i].exp_addr);
        end

        // Redirect while a response is outstanding: the late 0xDEADBEEF must be discarded.
        m_lat_min = 2; m_lat_max = 2;
        m_override_en = 1'b1; m_override_data = 32'hDEAD_BEEF;
        s_rv = 1'b1; s_bt = 1'b1; s_target = 32'h0000_0200;
        tick();
        clear_redirect(); s_iready = 1'b1;
        n0 = xfer_count; first_acc = 1'b1;
        for (int k = 0; k < 40 && xfer_count == n0; k++) begin
            tick();
            if (acc_seen && first_acc) begin
                chk("kill_req_addr", acc_addr, 32'h0000_0200);
                first_acc = 1'b0;
            end
        end
        chk("kill_dead_sent", {31'b0, m_dead_sent}, 32'd1);
        chk("kill_xfer_pc", last_xfer_pc, 32'h0000_0200);
        chk("kill_xfer_instr", last_xfer_instr, mem_word(32'h0000_0200));
        chk("kill_no_dead", {31'b0, saw_dead}, 32'd0);

        // Reset while a response is outstanding.
        for (int k = 0; k < 20 && !acc_seen; k++) tick();
        tick();
        s_rst = 1'b1;
        repeat (2) tick();
        chk("mid_rst_req", {31'b0, bus_if.imem_req_out}, 32'd0);
        chk("mid_rst_valid", {31'b0, bus_if.instr_valid_out}, 32'd0);
        s_rst = 1'b0;
        tick();
        chk("mid_rel_c1_req", {31'b0, bus_if.imem_req_out}, 32'd0);
        tick();
        chk("mid_rel_c2_req", {31'b0, bus_if.imem_req_out}, 32'd1);
        chk("mid_rel_c2_addr", bus_if.imem_addr_out, RESET_PC);

        // Random traffic against the program-order model.
        m_rand_ready = 1'b1; m_lat_min = 0; m_lat_max = 2;
        n0 = xfer_count;
        for (int c = 0; c < 3000; c++) begin
            s_rst    = ($urandom_range(0, 499) == 0);
            s_iready = ($urandom_range(0, 2) != 0);
            r        = $urandom_range(0, 99);
            s_trap    = (r < 3);
            s_trap_pc = 32'($urandom_range(0, 1023)) << 2;
            s_rv      = (r < 15);
            s_bt      = ($urandom_range(0, 1) == 1);
            s_target  = (32'($urandom_range(0, 1023)) << 2) | 32'($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);
            if ($urandom_range(0, 49) == 0) s_target = 32'hFFFF_FFFC;
            tick();
        end
        chk("random_progress", {31'b0, (xfer_count - n0) >= 200}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
